// File: rtl/rv_register_file.sv
// RV32I integer register file: x1..x31 storage, two combinational read ports, one write port.
// Optional write-first forwarding is compiled in with `define REGFILE_BYPASS_EN.
module rv_register_file (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  i_r_reg_num_1,
    input  logic [4:0]  i_r_reg_num_2,
    input  logic [4:0]  i_w_reg_num,
    input  logic [31:0] i_w_val,
    input  logic        op,
    output logic [31:0] r_reg_1,
    output logic [31:0] r_reg_2
);

    // x0 is hardwired to zero, so only x1..x31 hold state.
    logic [31:0] r_regs [1:31];
    logic        w_wr_active;
    logic [31:0] w_rd_1;
    logic [31:0] w_rd_2;

    assign w_wr_active = op && (i_w_reg_num != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 1; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_active) begin
            r_regs[i_w_reg_num] <= i_w_val;
        end
    end

    always_comb begin
        w_rd_1 = '0;
        if (!rst && (i_r_reg_num_1 != '0)) begin
            w_rd_1 = r_regs[i_r_reg_num_1];
`ifdef REGFILE_BYPASS_EN
            if (w_wr_active && (i_w_reg_num == i_r_reg_num_1)) begin
                w_rd_1 = i_w_val;
            end
`endif
        end
    end

    always_comb begin
        w_rd_2 = '0;
        if (!rst && (i_r_reg_num_2 != '0)) begin
            w_rd_2 = r_regs[i_r_reg_num_2];
`ifdef REGFILE_BYPASS_EN
            if (w_wr_active && (i_w_reg_num == i_r_reg_num_2)) begin
                w_rd_2 = i_w_val;
            end
`endif
        end
    end

    assign r_reg_1 = w_rd_1;
    assign r_reg_2 = w_rd_2;

endmodule

// File: tb/tb_rv_register_file.sv
// Self-checking bench for rv_register_file: directed scenarios plus randomized traffic
// against an array-based reference model. Honours REGFILE_BYPASS_EN when defined.
module tb_rv_register_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        op;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  wa;
    logic [31:0] wv;
    logic [31:0] rd1;
    logic [31:0] rd2;

    logic [31:0] model_regs [32];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rv_register_file dut (
        .clk           (clk),
        .rst           (rst),
        .i_r_reg_num_1 (ra1),
        .i_r_reg_num_2 (ra2),
        .i_w_reg_num   (wa),
        .i_w_val       (wv),
        .op            (op),
        .r_reg_1       (rd1),
        .r_reg_2       (rd2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Expected read value for the inputs currently driven.
    function automatic logic [31:0] model_read(input logic [4:0] idx);
        if (rst || idx == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (op && wa != 5'd0 && wa == idx) return wv;
`endif
        return model_regs[idx];
    endfunction

    // One clock: drive, check both ports mid-cycle, then update the model at the edge.
    task automatic step(input logic s_rst, input logic s_op, input logic [4:0] s_wa,
                        input logic [4:0] s_ra1, input logic [4:0] s_ra2,
                        input logic [31:0] s_wv, input string tag);
        rst = s_rst; op = s_op; wa = s_wa; ra1 = s_ra1; ra2 = s_ra2; wv = s_wv;
        @(negedge clk);
        check_val({tag, "_p1"}, rd1, model_read(ra1));
        check_val({tag, "_p2"}, rd2, model_read(ra2));
        @(posedge clk);
        if (s_rst) begin
            for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
        end else if (s_op && s_wa != 5'd0) begin
            model_regs[s_wa] = s_wv;
        end
        #1;
    endtask

    // Idle read with fixed expectations, taken just after an edge.
    task automatic peek(input logic [4:0] a1, input logic [4:0] a2,
                        input logic [31:0] e1, input logic [31:0] e2, input string tag);
        rst = 1'b0; op = 1'b0; ra1 = a1; ra2 = a2;
        #1;
        check_val({tag, "_p1"}, rd1, e1);
        check_val({tag, "_p2"}, rd2, e2);
    endtask

    initial begin
        logic [4:0]  r_wa, r_ra1, r_ra2;
        for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
        rst = 1'b1; op = 1'b0; wa = '0; ra1 = '0; ra2 = '0; wv = '0;

        step(1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 32'h0, "init_rst");
        step(1'b1, 1'b0, 5'd0, 5'd3, 5'd4, 32'h0, "init_rst2");

        for (int i = 1; i < 32; i++) begin
            step(1'b0, 1'b1, 5'(i), 5'(i), 5'(32 - i), 32'hA500_0000 | 32'(i), "fill");
        end
        peek(5'd1, 5'd31, 32'hA500_0001, 32'hA500_001F, "fill_chk");

        // Reset with a concurrent write: outputs 0 during reset, array cleared after.
        step(1'b1, 1'b1, 5'd9, 5'd9, 5'd17, 32'h1234_5678, "rst_on");
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b0, 5'd0, 5'(i), 5'(31 - i), 32'h0, "post_rst");
        end
        peek(5'd9, 5'd17, 32'h0, 32'h0, "post_rst_chk");

        step(1'b0, 1'b1, 5'd5, 5'd5, 5'd5, 32'hDEAD_BEEF, "wr5");
        peek(5'd5, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "rd5");
        peek(5'd6, 5'd6, 32'h0, 32'h0, "rd6");

        step(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, "wr0");
        peek(5'd0, 5'd0, 32'h0, 32'h0, "rd0");

        step(1'b0, 1'b1, 5'd7, 5'd0, 5'd0, 32'h1111_1111, "wr7a");
        rst = 1'b0; op = 1'b1; wa = 5'd7; wv = 32'h2222_2222; ra1 = 5'd7; ra2 = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        check_val("same_cyc7", rd1, 32'h2222_2222);
`else
        check_val("same_cyc7", rd1, 32'h1111_1111);
`endif
        step(1'b0, 1'b1, 5'd7, 5'd7, 5'd7, 32'h2222_2222, "wr7b");
        peek(5'd7, 5'd7, 32'h2222_2222, 32'h2222_2222, "rd7");

        step(1'b0, 1'b1, 5'd9, 5'd9, 5'd9, 32'hCAFE_0009, "wr9");
        step(1'b1, 1'b1, 5'd9, 5'd9, 5'd9, 32'h1234_5678, "rst_vs_wr");
        peek(5'd9, 5'd5, 32'h0, 32'h0, "rd9");

        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 5'd3, 5'd3, 5'd3, 32'hAAAA_5555, "op_gate");
        end
        peek(5'd3, 5'd3, 32'h0, 32'h0, "rd3");

        for (int n = 0; n < 400; n++) begin
            r_wa  = 5'($urandom_range(0, 31));
            r_ra1 = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom_range(0, 31));
            r_ra2 = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom_range(0, 31));
            step(($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)), r_wa, r_ra1, r_ra2,
                 32'($urandom), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
